// File: rtl/card_dealer.sv
// Card source for the hand-scoring logic: deals one rank per accepted request into a hand slot.
// Define DECK_TRACK_EN to model a finite shoe of NUM_DECKS decks with per-rank remaining counts.
module card_dealer #(
   parameter logic [3:0] SEED      = 4'd1,
   parameter int         NUM_DECKS = 8
) (
   input  logic       slow_clock,
   input  logic       reset,
   input  logic       deal_valid,
   input  logic [2:0] deal_slot,
   input  logic       new_round,
   output logic       deal_ready,
   output logic       done,
   output logic [3:0] card_out,
   output logic [3:0] pcard1,
   output logic [3:0] pcard2,
   output logic [3:0] pcard3,
   output logic [3:0] dcard1,
   output logic [3:0] dcard2,
   output logic [3:0] dcard3,
   output logic       shoe_empty
);

   if (SEED < 4'd1 || SEED > 4'd13) begin : g_bad_seed
      $error("card_dealer: SEED must be in 1..13");
   end
   if (NUM_DECKS < 1 || NUM_DECKS > 127) begin : g_bad_decks
      $error("card_dealer: NUM_DECKS must be in 1..127");
   end

   typedef enum logic [1:0] {IDLE, SEEK, WRITE} state_t;

   state_t     state;
   logic [3:0] rank;
   logic [3:0] lat_rank;
   logic [2:0] lat_slot;
   logic       slot_ok;
   logic       accept;

   function automatic logic [3:0] next_rank(input logic [3:0] r);
      return (r >= 4'd13) ? 4'd1 : r + 4'd1;
   endfunction

   assign slot_ok    = (lat_slot < 3'd6);
   assign deal_ready = (state == IDLE) && !shoe_empty;
   assign accept     = deal_valid && deal_ready;

   always_ff @(posedge slow_clock) begin
      if (reset) rank <= SEED;
      else       rank <= next_rank(rank);
   end

`ifdef DECK_TRACK_EN
   localparam logic [8:0] FULL_COUNT = 9'(4 * NUM_DECKS);

   logic [8:0]  remaining [13];
   logic [12:0] rank_left;
   logic [3:0]  lat_idx;

   assign lat_idx = lat_rank - 4'd1;
   for (genvar g = 0; g < 13; g++) begin : g_left
      assign rank_left[g] = |remaining[g];
   end
   assign shoe_empty = ~|rank_left;
`else
   assign shoe_empty = 1'b0;
`endif

   always_ff @(posedge slow_clock) begin
      if (reset) begin
         state    <= IDLE;
         lat_rank <= SEED;
         lat_slot <= 3'd0;
         done     <= 1'b0;
         card_out <= 4'd0;
         pcard1   <= 4'd0;
         pcard2   <= 4'd0;
         pcard3   <= 4'd0;
         dcard1   <= 4'd0;
         dcard2   <= 4'd0;
         dcard3   <= 4'd0;
`ifdef DECK_TRACK_EN
         // NOTE: remaining[] is a small flop array, not RAM, so it takes the reset; this is the only refill path.
         for (int i = 0; i < 13; i++) remaining[i] <= FULL_COUNT;
`endif
      end else begin
         done <= 1'b0;
         // NOTE: the slot write below is the later non-blocking assignment, so it beats this clear on the same edge.
         if (new_round) begin
            pcard1 <= 4'd0;
            pcard2 <= 4'd0;
            pcard3 <= 4'd0;
            dcard1 <= 4'd0;
            dcard2 <= 4'd0;
            dcard3 <= 4'd0;
         end
         case (state)
            IDLE: begin
               if (accept) begin
                  lat_slot <= deal_slot;
                  lat_rank <= rank;
`ifdef DECK_TRACK_EN
                  state    <= (deal_slot < 3'd6) ? SEEK : WRITE;
`else
                  state    <= WRITE;
`endif
               end
            end
`ifdef DECK_TRACK_EN
            SEEK: begin
               if (rank_left[lat_idx]) state <= WRITE;
               else                    lat_rank <= next_rank(lat_rank);
            end
`endif
            WRITE: begin
               done     <= 1'b1;
               card_out <= slot_ok ? lat_rank : 4'd0;
               case (lat_slot)
                  3'd0:    pcard1 <= lat_rank;
                  3'd1:    pcard2 <= lat_rank;
                  3'd2:    pcard3 <= lat_rank;
                  3'd3:    dcard1 <= lat_rank;
                  3'd4:    dcard2 <= lat_rank;
                  3'd5:    dcard3 <= lat_rank;
                  default: ;
               endcase
`ifdef DECK_TRACK_EN
               if (slot_ok) remaining[lat_idx] <= remaining[lat_idx] - 9'd1;
`endif
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_card_dealer.sv
// Directed self-checking bench for card_dealer (SEED=1, NUM_DECKS=1).
// Deck-exhaustion scenario runs only when DECK_TRACK_EN is defined.
module tb_card_dealer;

   logic       slow_clock = 1'b0;
   logic       reset      = 1'b1;
   logic       deal_valid = 1'b0;
   logic [2:0] deal_slot  = 3'd0;
   logic       new_round  = 1'b0;
   logic       deal_ready, done, shoe_empty;
   logic [3:0] card_out, pcard1, pcard2, pcard3, dcard1, dcard2, dcard3;
   logic [23:0] hand;

   int checks   = 0;
   int failures = 0;

   card_dealer #(.SEED(4'd1), .NUM_DECKS(1)) dut (
      .slow_clock(slow_clock),
      .reset     (reset),
      .deal_valid(deal_valid),
      .deal_slot (deal_slot),
      .new_round (new_round),
      .deal_ready(deal_ready),
      .done      (done),
      .card_out  (card_out),
      .pcard1    (pcard1),
      .pcard2    (pcard2),
      .pcard3    (pcard3),
      .dcard1    (dcard1),
      .dcard2    (dcard2),
      .dcard3    (dcard3),
      .shoe_empty(shoe_empty)
   );

   always #5 slow_clock = ~slow_clock;
   assign hand = {pcard1, pcard2, pcard3, dcard1, dcard2, dcard3};

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Leaves the bench at the falling edge just before post-reset cycle 0 (rank counter = 1).
   task automatic do_reset();
      reset      = 1'b1;
      deal_valid = 1'b0;
      deal_slot  = 3'd0;
      new_round  = 1'b0;
      @(posedge slow_clock);
      @(negedge slow_clock);
      reset = 1'b0;
   endtask

   // Presents one request to an idle dealer; returns at the falling edge before the write edge.
   task automatic deal(input logic [2:0] slot);
      deal_slot  = slot;
      deal_valid = 1'b1;
      @(negedge slow_clock);
      deal_valid = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (hand !== 24'h0) begin
         failures++; $display("FAIL reset_hand: got %h expected %h", hand, 24'h0);
      end
      checks++;
      if ({done, card_out, shoe_empty} !== 6'b0) begin
         failures++; $display("FAIL reset_outputs: got done=%b card_out=%0d shoe_empty=%b expected 0/0/0", done, card_out, shoe_empty);
      end
      checks++;
      if (deal_ready !== 1'b1) begin
         failures++; $display("FAIL reset_ready: got %b expected 1", deal_ready);
      end
   endtask

   task automatic test_first_deal();
      do_reset();
      deal(3'd0);
      checks++;
      if (deal_ready !== 1'b0) begin
         failures++; $display("FAIL first_deal_ready_low: got %b expected 0", deal_ready);
      end
      @(negedge slow_clock);
      checks++;
      if (hand !== {4'd1, 20'd0}) begin
         failures++; $display("FAIL first_deal_hand: got %h expected %h", hand, {4'd1, 20'd0});
      end
      checks++;
      if ({done, card_out} !== {1'b1, 4'd1}) begin
         failures++; $display("FAIL first_deal_done: got done=%b card_out=%0d expected 1/1", done, card_out);
      end
      // Accepted in cycle 2 -> rank 3, overwrites pcard1.
      deal(3'd0);
      @(negedge slow_clock);
      checks++;
      if (hand !== {4'd3, 20'd0}) begin
         failures++; $display("FAIL overwrite_hand: got %h expected %h", hand, {4'd3, 20'd0});
      end
      @(negedge slow_clock);
      checks++;
      if ({done, card_out} !== {1'b0, 4'd3}) begin
         failures++; $display("FAIL card_out_hold: got done=%b card_out=%0d expected 0/3", done, card_out);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      repeat (12) @(negedge slow_clock);
      deal(3'd3);
      @(negedge slow_clock);
      checks++;
      if (hand !== {12'd0, 4'd13, 8'd0}) begin
         failures++; $display("FAIL rank13_dcard1: got %h expected %h", hand, {12'd0, 4'd13, 8'd0});
      end
      do_reset();
      repeat (13) @(negedge slow_clock);
      deal(3'd4);
      @(negedge slow_clock);
      checks++;
      if (hand !== {16'd0, 4'd1, 4'd0}) begin
         failures++; $display("FAIL wrap_dcard2: got %h expected %h", hand, {16'd0, 4'd1, 4'd0});
      end
   endtask

   // Accepts land on cycles 0,2,..,10 -> ranks 1,3,5,7,9,11 into slots 0..5.
   task automatic test_back_to_back();
      int acc = 0;
      int dn  = 0;
      do_reset();
      deal_valid = 1'b1;
      for (int c = 0; c < 14; c++) begin
         if (done === 1'b1) dn++;
         if (acc < 6) begin
            checks++;
            if (deal_ready !== ((c % 2) == 0)) begin
               failures++; $display("FAIL b2b_ready cycle %0d: got %b expected %b", c, deal_ready, (c % 2) == 0);
            end
            if (deal_ready === 1'b1) begin
               deal_slot = 3'(acc);
               acc++;
            end
         end else begin
            deal_valid = 1'b0;
         end
         @(negedge slow_clock);
      end
      checks++;
      if (dn !== 6) begin
         failures++; $display("FAIL b2b_done_count: got %0d expected 6", dn);
      end
      checks++;
      if (hand !== {4'd1, 4'd3, 4'd5, 4'd7, 4'd9, 4'd11}) begin
         failures++; $display("FAIL b2b_hand: got %h expected %h", hand, {4'd1, 4'd3, 4'd5, 4'd7, 4'd9, 4'd11});
      end
   endtask

   // Runs straight after test_back_to_back with its hand still loaded.
   task automatic test_invalid_slot();
      for (int s = 6; s < 8; s++) begin
         deal(3'(s));
         @(negedge slow_clock);
         checks++;
         if ({done, card_out} !== {1'b1, 4'd0}) begin
            failures++; $display("FAIL invalid_slot%0d_done: got done=%b card_out=%0d expected 1/0", s, done, card_out);
         end
         checks++;
         if (hand !== {4'd1, 4'd3, 4'd5, 4'd7, 4'd9, 4'd11}) begin
            failures++; $display("FAIL invalid_slot%0d_hand: got %h expected %h", s, hand, {4'd1, 4'd3, 4'd5, 4'd7, 4'd9, 4'd11});
         end
      end
   endtask

   task automatic test_new_round();
      do_reset();
      deal(3'd0);
      @(negedge slow_clock);
      deal(3'd5);
      @(negedge slow_clock);
      checks++;
      if (hand !== {4'd1, 16'd0, 4'd3}) begin
         failures++; $display("FAIL new_round_preload: got %h expected %h", hand, {4'd1, 16'd0, 4'd3});
      end
      // Accept slot 2 in cycle 4 (rank 5), then pulse new_round during its write cycle.
      deal_slot  = 3'd2;
      deal_valid = 1'b1;
      @(negedge slow_clock);
      deal_valid = 1'b0;
      new_round  = 1'b1;
      @(negedge slow_clock);
      new_round = 1'b0;
      checks++;
      if (hand !== {8'd0, 4'd5, 12'd0}) begin
         failures++; $display("FAIL new_round_write_wins: got %h expected %h", hand, {8'd0, 4'd5, 12'd0});
      end
      checks++;
      if (done !== 1'b1) begin
         failures++; $display("FAIL new_round_done: got %b expected 1", done);
      end
      new_round = 1'b1;
      @(negedge slow_clock);
      new_round = 1'b0;
      checks++;
      if ({hand, card_out} !== {24'd0, 4'd5}) begin
         failures++; $display("FAIL new_round_idle_clear: got hand=%h card_out=%0d expected 000000/5", hand, card_out);
      end
   endtask

   task automatic test_reset_mid_deal();
      do_reset();
      deal(3'd1);
      reset = 1'b1;
      @(negedge slow_clock);
      reset = 1'b0;
      checks++;
      if ({hand, done, card_out} !== 29'd0) begin
         failures++; $display("FAIL reset_mid_deal: got hand=%h done=%b card_out=%0d expected all 0", hand, done, card_out);
      end
      checks++;
      if (deal_ready !== 1'b1) begin
         failures++; $display("FAIL reset_mid_deal_ready: got %b expected 1", deal_ready);
      end
   endtask

`ifdef DECK_TRACK_EN
   task automatic test_deck_exhaust();
      int tally [1:13];
      int dn = 0;
      logic got;
      for (int r = 1; r <= 13; r++) tally[r] = 0;
      do_reset();
      for (int d = 0; d < 52; d++) begin
         got        = 1'b0;
         deal_slot  = 3'(d % 6);
         deal_valid = 1'b1;
         for (int c = 0; c < 30 && !got; c++) begin
            if (deal_ready === 1'b1 && deal_valid === 1'b1) begin
               @(negedge slow_clock);
               deal_valid = 1'b0;
            end else begin
               @(negedge slow_clock);
            end
            if (done === 1'b1) begin
               got = 1'b1;
               if (card_out >= 4'd1 && card_out <= 4'd13) tally[card_out]++;
            end
         end
         deal_valid = 1'b0;
         if (!got) begin
            checks++; failures++;
            $display("FAIL deck_deal_timeout: deal %0d got no done expected done within 30 cycles", d);
         end
      end
      for (int r = 1; r <= 13; r++) begin
         checks++;
         if (tally[r] !== 4) begin
            failures++; $display("FAIL deck_rank%0d_count: got %0d expected 4", r, tally[r]);
         end
      end
      checks++;
      if ({shoe_empty, deal_ready} !== 2'b10) begin
         failures++; $display("FAIL deck_empty_flags: got shoe_empty=%b deal_ready=%b expected 1/0", shoe_empty, deal_ready);
      end
      deal_slot  = 3'd0;
      deal_valid = 1'b1;
      repeat (20) begin
         @(negedge slow_clock);
         if (done === 1'b1) dn++;
      end
      deal_valid = 1'b0;
      checks++;
      if (dn !== 0) begin
         failures++; $display("FAIL deck_53rd_deal: got %0d done pulses expected 0", dn);
      end
      do_reset();
      checks++;
      if ({shoe_empty, deal_ready} !== 2'b01) begin
         failures++; $display("FAIL deck_refill: got shoe_empty=%b deal_ready=%b expected 0/1", shoe_empty, deal_ready);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_first_deal();
      test_wrap();
      test_back_to_back();
      test_invalid_slot();
      test_new_round();
      test_reset_mid_deal();
`ifdef DECK_TRACK_EN
      test_deck_exhaust();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
